// File: rtl/exec_mul_wb_pkg.sv
// -----------------------------------------------------------------------------
// exec_mul_wb_pkg
// Shared CPU package slice used by the multiply write-back stage.
// Contents:
//   mulWbState_t - write-back sequencer state encoding
//   REG_AX/REG_DX - register-file indices of the accumulator and data registers
// -----------------------------------------------------------------------------
package exec_mul_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } mulWbState_t;

    localparam logic [2:0] REG_AX = 3'd0;
    localparam logic [2:0] REG_DX = 3'd2;

endpackage

// File: rtl/exec_mul_wb_flags.sv
// -----------------------------------------------------------------------------
// exec_mul_flags
// Carry/overflow flags for a MUL/IMUL result. Both flags say the same thing:
// the product does not fit in the destination width of the operands.
// Ports:
//   iBW   - 0 = byte multiply (product in lo), 1 = word multiply (hi:lo)
//   iESel - 0 = unsigned, 1 = signed
//   lo    - low product word
//   hi    - high product word
//   CF    - carry flag
//   OF    - overflow flag
// -----------------------------------------------------------------------------
module exec_mul_flags (
    input  logic        iBW,
    input  logic        iESel,
    input  logic [15:0] lo,
    input  logic [15:0] hi,
    output logic        CF,
    output logic        OF
);

    logic spill;
    logic unusedLoBits;

    // The low seven bits never decide whether a product overflowed.
    assign unusedLoBits = ^lo[6:0];

    // Signed results fit when the upper half is a pure sign extension of the
    // lower half; unsigned results fit when the upper half is zero.
    always_comb begin
        // NOTE: default first so every path assigns spill and no latch is inferred.
        spill = 1'b0;
        case ({iBW, iESel})
            2'b00:   spill = |lo[15:8];
            2'b01:   spill = (lo[15:8] != {8{lo[7]}});
            2'b10:   spill = |hi;
            default: spill = (hi != {16{lo[15]}});
        endcase
    end

    assign CF = spill;
    assign OF = spill;

endmodule

// File: rtl/exec_mul_wb.sv
// -----------------------------------------------------------------------------
// exec_mul_wb
// Multiply write-back stage. Accepts one multiplier result, writes the low
// word to AX and (word multiply only) the high word to DX through a single
// register-file write port that can stall, then pulses oDone/oFlagWe with the
// final write. CF/OF are computed at accept and held until the next accept.
// Ports:
//   iClk, iRst          - clock, asynchronous active-high reset
//   iValid / oReady     - result handshake (oReady only in IDLE)
//   iBW, iESel          - byte/word and unsigned/signed selects
//   iMulOut, iMulOutHi  - low / high product words
//   iWrStall            - write port busy, hold the current write
//   oWrEn/oWrAddr/oWrData - register-file write port
//   oFlagWe, oCF, oOF   - flag update strobe and values
//   oDone               - completion pulse
// -----------------------------------------------------------------------------
module exec_mul_wb
    import exec_mul_wb_pkg::*;
#(
    parameter logic [2:0] AX_IDX = REG_AX,
    parameter logic [2:0] DX_IDX = REG_DX
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    output logic        oReady,
    input  logic        iBW,
    input  logic        iESel,
    input  logic [15:0] iMulOut,
    input  logic [15:0] iMulOutHi,
    input  logic        iWrStall,
    output logic        oWrEn,
    output logic [2:0]  oWrAddr,
    output logic [15:0] oWrData,
    output logic        oFlagWe,
    output logic        oCF,
    output logic        oOF,
    output logic        oDone
);

    mulWbState_t state;
    mulWbState_t nextState;

    logic        capBW;
    logic [15:0] capLo;
    logic [15:0] capHi;
    logic        capCF;
    logic        capOF;

    logic        flagCF;
    logic        flagOF;
    logic        accept;

    assign accept = iValid && oReady;

    exec_mul_flags uFlags (
        .iBW   (iBW),
        .iESel (iESel),
        .lo    (iMulOut),
        .hi    (iMulOutHi),
        .CF    (flagCF),
        .OF    (flagOF)
    );

    // State register and capture registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            // NOTE: capture registers are reset too, so the held flags read 0
            // after reset rather than stale data from an aborted transaction.
            state <= IDLE;
            capBW <= 1'b0;
            capLo <= '0;
            capHi <= '0;
            capCF <= 1'b0;
            capOF <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state <= nextState;
            if (accept) begin
                capBW <= iBW;
                capLo <= iMulOut;
                capHi <= iMulOutHi;
                capCF <= flagCF;
                capOF <= flagOF;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iValid) nextState = WR_LO;
            WR_LO:   if (!iWrStall) nextState = capBW ? WR_HI : IDLE;
            WR_HI:   if (!iWrStall) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic. The write that completes the sequence is the one whose
    // stall is low in WR_HI, or in WR_LO for a byte multiply.
    always_comb begin
        oReady  = 1'b0;
        oWrEn   = 1'b0;
        oWrAddr = '0;
        oWrData = '0;
        oDone   = 1'b0;
        case (state)
            IDLE: begin
                oReady = 1'b1;
            end
            WR_LO: begin
                oWrEn   = 1'b1;
                oWrAddr = AX_IDX;
                oWrData = capLo;
                oDone   = !iWrStall && !capBW;
            end
            WR_HI: begin
                oWrEn   = 1'b1;
                oWrAddr = DX_IDX;
                oWrData = capHi;
                oDone   = !iWrStall;
            end
            default: ;
        endcase
    end

    assign oFlagWe = oDone;
    assign oCF     = capCF;
    assign oOF     = capOF;

endmodule

// File: tb/tb_exec_mul_wb.sv
// -----------------------------------------------------------------------------
// tb_exec_mul_wb
// Self-checking bench for exec_mul_wb. Inputs change on the falling edge and
// outputs are observed there (1 time unit after any input change), away from
// the rising edge where the DUT updates. Expected flags come from a range
// model: a product overflows when its value does not fit the operand width.
// -----------------------------------------------------------------------------
module tb_exec_mul_wb;

    localparam logic [2:0] AX = 3'd0;
    localparam logic [2:0] DX = 3'd2;

    logic        iClk;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic        iBW;
    logic        iESel;
    logic [15:0] iMulOut;
    logic [15:0] iMulOutHi;
    logic        iWrStall;
    logic        oWrEn;
    logic [2:0]  oWrAddr;
    logic [15:0] oWrData;
    logic        oFlagWe;
    logic        oCF;
    logic        oOF;
    logic        oDone;

    int checks = 0;
    int errors = 0;

    exec_mul_wb dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iBW       (iBW),
        .iESel     (iESel),
        .iMulOut   (iMulOut),
        .iMulOutHi (iMulOutHi),
        .iWrStall  (iWrStall),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oFlagWe   (oFlagWe),
        .oCF       (oCF),
        .oOF       (oOF),
        .oDone     (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Overflow model: does the numeric product fit the destination width?
    function automatic logic expOverflow(input logic bw, input logic esel,
                                         input logic [15:0] lo, input logic [15:0] hi);
        longint v;
        if (!bw) begin
            if (esel) begin
                v = longint'($signed(lo));
                return (v < -128) || (v > 127);
            end
            v = longint'(lo);
            return v > 255;
        end
        if (esel) begin
            v = longint'($signed({hi, lo}));
            return (v < -32768) || (v > 32767);
        end
        v = longint'({hi, lo});
        return v > 65535;
    endfunction

    // Scramble inputs that must be ignored outside IDLE.
    task automatic scramble();
        iValid    = 1'($urandom);
        iBW       = 1'($urandom);
        iESel     = 1'($urandom);
        iMulOut   = 16'($urandom);
        iMulOutHi = 16'($urandom);
    endtask

    // One write phase: stalls cycles held, then the completing cycle.
    task automatic writePhase(input string tag, input logic [2:0] addr, input logic [15:0] data,
                              input int stalls, input logic last, input logic expF);
        for (int k = 0; k <= stalls; k++) begin
            scramble();
            iWrStall = (k < stalls);
            #1;
            check({tag, "_wren"}, 16'(oWrEn), 16'd1);
            check({tag, "_addr"}, 16'(oWrAddr), 16'(addr));
            check({tag, "_data"}, oWrData, data);
            check({tag, "_ready"}, 16'(oReady), 16'd0);
            check({tag, "_done"}, 16'(oDone), 16'(last && (k == stalls)));
            check({tag, "_flagwe"}, 16'(oFlagWe), 16'(last && (k == stalls)));
            check({tag, "_cf"}, 16'(oCF), 16'(expF));
            check({tag, "_of"}, 16'(oOF), 16'(expF));
            @(negedge iClk);
        end
        iWrStall = 1'b0;
    endtask

    // Full transaction from IDLE back to IDLE.
    task automatic doTxn(input logic bw, input logic esel, input logic [15:0] lo,
                         input logic [15:0] hi, input int stallLo, input int stallHi);
        logic expF;
        expF = expOverflow(bw, esel, lo, hi);
        #1;
        check("accept_ready", 16'(oReady), 16'd1);
        iValid    = 1'b1;
        iBW       = bw;
        iESel     = esel;
        iMulOut   = lo;
        iMulOutHi = hi;
        @(negedge iClk);
        writePhase("wr_lo", AX, lo, stallLo, !bw, expF);
        if (bw) writePhase("wr_hi", DX, hi, stallHi, 1'b1, expF);
        iValid = 1'b0;
        #1;
        check("idle_ready", 16'(oReady), 16'd1);
        check("idle_wren", 16'(oWrEn), 16'd0);
        check("idle_addr", 16'(oWrAddr), 16'd0);
        check("idle_data", oWrData, 16'd0);
        check("idle_done", 16'(oDone), 16'd0);
        check("idle_cf_hold", 16'(oCF), 16'(expF));
        check("idle_of_hold", 16'(oOF), 16'(expF));
    endtask

    initial begin
        logic        bw;
        logic        esel;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;

        iRst      = 1'b1;
        iValid    = 1'b0;
        iBW       = 1'b0;
        iESel     = 1'b0;
        iMulOut   = '0;
        iMulOutHi = '0;
        iWrStall  = 1'b0;
        #1;
        check("rst_ready", 16'(oReady), 16'd1);
        check("rst_wren", 16'(oWrEn), 16'd0);
        check("rst_done", 16'(oDone), 16'd0);
        check("rst_flagwe", 16'(oFlagWe), 16'd0);
        check("rst_cf", 16'(oCF), 16'd0);
        check("rst_of", 16'(oOF), 16'd0);
        check("rst_data", oWrData, 16'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);

        // Directed cases.
        doTxn(1'b0, 1'b0, 16'h0100, 16'h0000, 0, 0);
        doTxn(1'b0, 1'b1, 16'hFF80, 16'h0000, 0, 0);
        doTxn(1'b0, 1'b1, 16'h0001, 16'h0000, 0, 0);
        doTxn(1'b1, 1'b0, 16'h3400, 16'h0012, 0, 0);
        doTxn(1'b1, 1'b1, 16'h8000, 16'h0000, 0, 0);
        doTxn(1'b1, 1'b1, 16'h8000, 16'hFFFF, 0, 0);
        doTxn(1'b1, 1'b0, 16'hBEEF, 16'h0000, 0, 3);
        doTxn(1'b0, 1'b0, 16'h00FF, 16'h1234, 2, 0);

        // Reset in WR_HI aborts the write without a completion pulse.
        #1;
        check("abort_ready", 16'(oReady), 16'd1);
        iValid    = 1'b1;
        iBW       = 1'b1;
        iESel     = 1'b0;
        iMulOut   = 16'h1234;
        iMulOutHi = 16'h5678;
        @(negedge iClk);
        iValid = 1'b0;
        @(negedge iClk);
        #1;
        check("abort_pre_addr", 16'(oWrAddr), 16'(DX));
        check("abort_pre_cf", 16'(oCF), 16'd1);
        iRst = 1'b1;
        #1;
        check("abort_wren", 16'(oWrEn), 16'd0);
        check("abort_done", 16'(oDone), 16'd0);
        check("abort_flagwe", 16'(oFlagWe), 16'd0);
        check("abort_ready_rst", 16'(oReady), 16'd1);
        check("abort_cf", 16'(oCF), 16'd0);
        check("abort_data", oWrData, 16'd0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        #1;
        check("abort_post_ready", 16'(oReady), 16'd1);
        check("abort_post_wren", 16'(oWrEn), 16'd0);
        check("abort_post_done", 16'(oDone), 16'd0);
        doTxn(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);

        // Randomized products from real operands.
        for (int n = 0; n < 40; n++) begin
            bw   = 1'($urandom);
            esel = 1'($urandom);
            a    = 16'($urandom);
            b    = 16'($urandom);
            if (!bw) begin
                if (esel) p = 32'($signed(a[7:0]) * $signed(b[7:0]));
                else      p = 32'(a[7:0]) * 32'(b[7:0]);
                // The high word is unused for byte multiplies; feed noise.
                doTxn(bw, esel, p[15:0], 16'($urandom), $urandom_range(0, 2), 0);
            end else begin
                if (esel) p = 32'($signed(a) * $signed(b));
                else      p = 32'(a) * 32'(b);
                doTxn(bw, esel, p[15:0], p[31:16], $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
